proj_seq_checker: RTL and testbench

- Receive-side checker for the 4-bit word stream produced by the lab's direct-output 5-flop sequence generator.
- The generator's fifth state bit (e) is hidden, so the checker infers it:
  - it seeds two candidate states from the first word received;
  - it eliminates the candidate that mispredicts;
  - it then tracks the stream and counts errors.
- It sits at the far end of the generator's y bus, on the FPGA board or in a bench, and drives lock and error indicators (LEDs).

---
 rtl/proj_seq_pkg.sv | 37 +++
 rtl/proj_seq_checker_predictor.sv | 16 +
 rtl/proj_seq_checker.sv | 224 ++++++++++++++++++++++
 tb/tb_proj_seq_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/proj_seq_pkg.sv
// proj_seq_pkg -- shared types and the generator model for the sequence checker.
//   seq_state_e : checker FSM states
//   gen_state_t : 5-bit generator state {e,d,c,b,a}
//   BIT_*       : bit positions inside gen_state_t
//   gen_next()  : one step of the 5-flop generator
//   gen_word()  : visible word {d,c,b,a} of a generator state
package proj_seq_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    RESOLVE = 2'd1,
    LOCK    = 2'd2
  } seq_state_e;

  typedef logic [4:0] gen_state_t;

  localparam int unsigned BIT_A = 0;
  localparam int unsigned BIT_B = 1;
  localparam int unsigned BIT_C = 2;
  localparam int unsigned BIT_D = 3;
  localparam int unsigned BIT_E = 4;

  function automatic gen_state_t gen_next(input gen_state_t s);
    gen_state_t n;
    n[BIT_A] = s[BIT_E] & s[BIT_B];
    n[BIT_B] = s[BIT_A] | (s[BIT_E] & s[BIT_C]);
    n[BIT_C] = s[BIT_D] | (~s[BIT_E] & s[BIT_B]);
    n[BIT_D] = s[BIT_C] & ~s[BIT_E];
    n[BIT_E] = s[BIT_A] ^ s[BIT_D] ^ s[BIT_E];
    return n;
  endfunction

  function automatic logic [3:0] gen_word(input gen_state_t s);
    return s[BIT_D:BIT_A];
  endfunction

endpackage

// File: rtl/proj_seq_checker_predictor.sv
// proj_seq_predictor -- combinational one-step prediction of the generator.
//   i_state : current candidate state {e,d,c,b,a}
//   o_next  : successor state
//   o_word  : visible word of the successor, i.e. the word expected next
module proj_seq_predictor
  import proj_seq_pkg::*;
(
  input  gen_state_t  i_state,
  output gen_state_t  o_next,
  output logic [3:0]  o_word
);

  assign o_next = gen_next(i_state);
  assign o_word = gen_word(o_next);

endmodule

// File: rtl/proj_seq_checker.sv
// proj_seq_checker -- receive-side checker for the 5-flop generator word stream.
// The generator's e bit is invisible, so the first word seeds two candidates
// (e=0 and e=1); mispredicting candidates are dropped until one remains, after
// which that candidate is tracked and mismatches are counted.
//
// Build option: define SEQ_CHK_FLYWHEEL_EN to tolerate up to MISS_LIMIT-1
// consecutive mismatches in LOCK (the tracker freewheels through them).
// Without it, the first mismatch in LOCK drops back to HUNT.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   in_valid in_word carries a new generator word
//   in_word  received word {d,c,b,a}
//   locked   high while in LOCK
//   err      one-cycle pulse on a mismatch in LOCK
//   err_cnt  saturating count of LOCK mismatches (cleared only by rst)
//   exp_word next predicted word while locked, otherwise 0
//
// state   | meaning
// HUNT    | no candidates; next valid word seeds both
// RESOLVE | eliminating candidates, counting consecutive correct predictions
// LOCK    | single tracker in cand0 slot, checking every word
module proj_seq_checker
  import proj_seq_pkg::*;
#(
  parameter int SYNC_LEN   = 3,
  parameter int MISS_LIMIT = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_word,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       exp_word
);

  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam logic [MATCH_W-1:0] SYNC_V = MATCH_W'(SYNC_LEN);

  if (SYNC_LEN < 1) begin : g_bad_sync_len
    $error("SYNC_LEN must be at least 1");
  end
  if (MISS_LIMIT < 1) begin : g_bad_miss_limit
    $error("MISS_LIMIT must be at least 1");
  end

  seq_state_e         r_state, w_state_nxt;
  gen_state_t         r_cand0, r_cand1, w_cand0_nxt, w_cand1_nxt;
  logic               r_alive0, r_alive1, w_alive0_nxt, w_alive1_nxt;
  logic [MATCH_W-1:0] r_match, w_match_nxt, w_match_inc;

  gen_state_t         w_next0, w_next1;
  logic [3:0]         w_word0, w_word1;
  logic               w_surv0, w_surv1, w_lock_hit, w_err_hit;

  logic               r_locked, r_err, w_locked_d;
  logic [CNT_W-1:0]   r_err_cnt, w_cnt_d;
  logic [3:0]         r_exp_word, w_exp_d;

`ifdef SEQ_CHK_FLYWHEEL_EN
  localparam int MISS_W = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT + 1);
  localparam logic [MISS_W-1:0] MISS_LIM_V = MISS_W'(MISS_LIMIT);
  logic [MISS_W-1:0]  r_miss, w_miss_nxt, w_miss_inc;
  assign w_miss_inc = r_miss + MISS_W'(1);
`endif

  proj_seq_predictor u_pred0 (
    .i_state (r_cand0),
    .o_next  (w_next0),
    .o_word  (w_word0)
  );

  proj_seq_predictor u_pred1 (
    .i_state (r_cand1),
    .o_next  (w_next1),
    .o_word  (w_word1)
  );

  assign w_surv0     = r_alive0 && (w_word0 == in_word);
  assign w_surv1     = r_alive1 && (w_word1 == in_word);
  assign w_lock_hit  = (w_word0 == in_word);
  assign w_match_inc = (r_match == SYNC_V) ? r_match : r_match + MATCH_W'(1);

  // State and datapath register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= HUNT;
      r_cand0  <= '0;
      r_cand1  <= '0;
      r_alive0 <= 1'b0;
      r_alive1 <= 1'b0;
      r_match  <= '0;
`ifdef SEQ_CHK_FLYWHEEL_EN
      r_miss   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cand0  <= w_cand0_nxt;
      r_cand1  <= w_cand1_nxt;
      r_alive0 <= w_alive0_nxt;
      r_alive1 <= w_alive1_nxt;
      r_match  <= w_match_nxt;
`ifdef SEQ_CHK_FLYWHEEL_EN
      r_miss   <= w_miss_nxt;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cand0_nxt  = r_cand0;
    w_cand1_nxt  = r_cand1;
    w_alive0_nxt = r_alive0;
    w_alive1_nxt = r_alive1;
    w_match_nxt  = r_match;
    w_err_hit    = 1'b0;
`ifdef SEQ_CHK_FLYWHEEL_EN
    w_miss_nxt   = r_miss;
`endif
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          w_cand0_nxt  = {1'b0, in_word};
          w_cand1_nxt  = {1'b1, in_word};
          w_alive0_nxt = 1'b1;
          w_alive1_nxt = 1'b1;
          w_match_nxt  = '0;
          w_state_nxt  = RESOLVE;
        end
        RESOLVE: begin
          if (!w_surv0 && !w_surv1) begin
            // Both guesses wrong: this word is a fresh starting point.
            w_cand0_nxt  = {1'b0, in_word};
            w_cand1_nxt  = {1'b1, in_word};
            w_alive0_nxt = 1'b1;
            w_alive1_nxt = 1'b1;
            w_match_nxt  = '0;
          end else begin
            w_alive0_nxt = w_surv0;
            w_alive1_nxt = w_surv1;
            w_match_nxt  = w_match_inc;
            if (w_surv0) w_cand0_nxt = w_next0;
            if (w_surv1) w_cand1_nxt = w_next1;
            // Both alive (e.g. the all-zero fixed point) keeps us here.
            if ((w_surv0 ^ w_surv1) && (w_match_inc >= SYNC_V)) begin
              w_state_nxt  = LOCK;
              w_cand0_nxt  = w_surv0 ? w_next0 : w_next1;
              w_alive0_nxt = 1'b1;
              w_alive1_nxt = 1'b0;
`ifdef SEQ_CHK_FLYWHEEL_EN
              w_miss_nxt   = '0;
`endif
            end
          end
        end
        LOCK: begin
          // Tracker advances on every valid word, matched or not.
          w_cand0_nxt = w_next0;
          if (w_lock_hit) begin
`ifdef SEQ_CHK_FLYWHEEL_EN
            w_miss_nxt = '0;
`endif
          end else begin
            w_err_hit = 1'b1;
`ifdef SEQ_CHK_FLYWHEEL_EN
            if (w_miss_inc >= MISS_LIM_V) begin
              w_state_nxt  = HUNT;
              w_alive0_nxt = 1'b0;
              w_alive1_nxt = 1'b0;
              w_miss_nxt   = '0;
            end else begin
              w_miss_nxt   = w_miss_inc;
            end
`else
            w_state_nxt  = HUNT;
            w_alive0_nxt = 1'b0;
            w_alive1_nxt = 1'b0;
`endif
          end
        end
        default: begin
          w_state_nxt  = HUNT;
          w_alive0_nxt = 1'b0;
          w_alive1_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output decode, registered below so every output updates one cycle after its word
  always_comb begin
    w_locked_d = (w_state_nxt == LOCK);
    w_exp_d    = w_locked_d ? gen_word(gen_next(w_cand0_nxt)) : 4'd0;
    w_cnt_d    = r_err_cnt;
    if (w_err_hit && (r_err_cnt != {CNT_W{1'b1}})) begin
      w_cnt_d = r_err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_exp_word <= 4'd0;
    end else begin
      r_locked   <= w_locked_d;
      r_err      <= w_err_hit;
      r_err_cnt  <= w_cnt_d;
      r_exp_word <= w_exp_d;
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;
  assign exp_word = r_exp_word;

endmodule

// File: tb/tb_proj_seq_checker.sv
module tb_proj_seq_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_word;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [3:0] exp_word;

  int n_tests;
  int n_fail;
  int m_cnt;

`ifdef SEQ_CHK_FLYWHEEL_EN
  localparam int MISSES_TO_DROP = 2;
`else
  localparam int MISSES_TO_DROP = 1;
`endif

  typedef struct {
    logic       v;
    logic [3:0] w;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [13];

  proj_seq_checker #(
    .SYNC_LEN   (3),
    .MISS_LIMIT (2),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_word  (in_word),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .exp_word (exp_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input logic l, input logic e,
                           input logic [7:0] c, input logic [3:0] x);
    check({tag, ".locked"},   int'(locked),   int'(l));
    check({tag, ".err"},      int'(err),      int'(e));
    check({tag, ".err_cnt"},  int'(err_cnt),  int'(c));
    check({tag, ".exp_word"}, int'(exp_word), int'(x));
  endtask

  // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
  task automatic send(input logic v, input logic [3:0] w);
    @(negedge clk);
    in_valid = v;
    in_word  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic relock(input string tag);
    send(1'b1, 4'd2);
    send(1'b1, 4'd4);
    send(1'b1, 4'd8);
    send(1'b1, 4'd4);
    check({tag, ".relock"}, int'(locked), 1);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    m_cnt    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_word  = 4'd0;

    // word 2 seeds, 4 kills the e=1 guess, 8 and 4 complete the sync run,
    // then the locked stream follows the period-6 cycle; one idle slot in between.
    tbl[0]  = '{1'b1, 4'd2, 1'b0, 1'b0, 8'd0, 4'd0};
    tbl[1]  = '{1'b1, 4'd4, 1'b0, 1'b0, 8'd0, 4'd0};
    tbl[2]  = '{1'b1, 4'd8, 1'b0, 1'b0, 8'd0, 4'd0};
    tbl[3]  = '{1'b1, 4'd4, 1'b1, 1'b0, 8'd0, 4'd2};
    tbl[4]  = '{1'b1, 4'd2, 1'b1, 1'b0, 8'd0, 4'd1};
    tbl[5]  = '{1'b1, 4'd1, 1'b1, 1'b0, 8'd0, 4'd2};
    tbl[6]  = '{1'b1, 4'd2, 1'b1, 1'b0, 8'd0, 4'd4};
    tbl[7]  = '{1'b1, 4'd4, 1'b1, 1'b0, 8'd0, 4'd8};
    tbl[8]  = '{1'b0, 4'd5, 1'b1, 1'b0, 8'd0, 4'd8};
    tbl[9]  = '{1'b1, 4'd8, 1'b1, 1'b0, 8'd0, 4'd4};
    tbl[10] = '{1'b1, 4'd4, 1'b1, 1'b0, 8'd0, 4'd2};
    tbl[11] = '{1'b1, 4'd2, 1'b1, 1'b0, 8'd0, 4'd1};
    tbl[12] = '{1'b1, 4'd1, 1'b1, 1'b0, 8'd0, 4'd2};

    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 8'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      send(tbl[i].v, tbl[i].w);
      check_all($sformatf("vec%0d", i), tbl[i].locked, tbl[i].err, tbl[i].cnt, tbl[i].exp);
    end

    // Locked, expecting 2 then 4.
`ifdef SEQ_CHK_FLYWHEEL_EN
    send(1'b1, 4'd5); m_cnt++;
    check_all("fly_miss", 1'b1, 1'b1, 8'(m_cnt), 4'd4);
    send(1'b1, 4'd4);
    check_all("fly_resume", 1'b1, 1'b0, 8'(m_cnt), 4'd8);
    send(1'b1, 4'd5); m_cnt++;
    check_all("fly_miss1", 1'b1, 1'b1, 8'(m_cnt), 4'd4);
    send(1'b1, 4'd5); m_cnt++;
    check_all("fly_miss2", 1'b0, 1'b1, 8'(m_cnt), 4'd0);
`else
    send(1'b1, 4'd5); m_cnt++;
    check_all("nofly_miss", 1'b0, 1'b1, 8'(m_cnt), 4'd0);
    send(1'b0, 4'd0);
    check_all("nofly_idle", 1'b0, 1'b0, 8'(m_cnt), 4'd0);
    relock("nofly");
    send(1'b1, 4'd5); m_cnt++;
    check_all("nofly_miss2", 1'b0, 1'b1, 8'(m_cnt), 4'd0);
`endif
    send(1'b0, 4'd0);
    check_all("drop_idle", 1'b0, 1'b0, 8'(m_cnt), 4'd0);

    // All-zero is a fixed point: both guesses survive, so no lock.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 4'd0);
      check($sformatf("zero%0d.locked", i), int'(locked), 0);
    end
    // 2 kills both, reseeds; 4,8,4 must then lock.
    send(1'b1, 4'd2);
    check_all("reseed", 1'b0, 1'b0, 8'(m_cnt), 4'd0);
    send(1'b1, 4'd4);
    send(1'b1, 4'd8);
    check("reseed_8.locked", int'(locked), 0);
    send(1'b1, 4'd4);
    check_all("reseed_lock", 1'b1, 1'b0, 8'(m_cnt), 4'd2);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 8'd0, 4'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_cnt = 0;
    send(1'b1, 4'd2);
    check("post_rst_seed.locked", int'(locked), 0);
    send(1'b1, 4'd4);
    send(1'b1, 4'd8);
    send(1'b1, 4'd4);
    check_all("post_rst_lock", 1'b1, 1'b0, 8'd0, 4'd2);

    // Idle for 10 cycles with junk on the bus.
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 4'(i + 3));
      check_all($sformatf("hold%0d", i), 1'b1, 1'b0, 8'd0, 4'd2);
    end

    // Saturation: drop out of lock repeatedly with word 15 (never predicted).
    send(1'b1, 4'd15); m_cnt++;
    check("sat_first.err", int'(err), 1);
    for (int k = 1; k < MISSES_TO_DROP; k++) begin
      send(1'b1, 4'd15); m_cnt++;
    end
    check("sat_first.locked", int'(locked), 0);
    while (m_cnt < 300) begin
      relock($sformatf("sat%0d", m_cnt));
      for (int k = 0; k < MISSES_TO_DROP; k++) begin
        send(1'b1, 4'd15); m_cnt++;
        check($sformatf("sat%0d.err", m_cnt), int'(err), 1);
        check($sformatf("sat%0d.err_cnt", m_cnt), int'(err_cnt),
              (m_cnt > 255) ? 255 : m_cnt);
      end
      check($sformatf("sat%0d.locked", m_cnt), int'(locked), 0);
    end
    send(1'b0, 4'd0);
    check_all("sat_final", 1'b0, 1'b0, 8'd255, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
